// File: rtl/keccak_chi_pipe.sv
// Two-stage masked Keccak chi layer (any order d) with elastic valid/ready handshake.
// Optional debug output out_plain (recombined result) when KECCAK_CHI_DBG_EN is defined.
module keccak_chi_pipe #(
  parameter int d    = 1,
  parameter int ROWS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [5*ROWS*(d+1)-1:0]       in_shares,
  input  logic [ROWS*5*d*(d+1)/2-1:0]   r,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [5*ROWS*(d+1)-1:0]       out_shares
`ifdef KECCAK_CHI_DBG_EN
  ,
  output logic [5*ROWS-1:0]             out_plain
`endif
);

  localparam int SH = d + 1;
  localparam int NB = 5 * ROWS * SH;
  localparam int NQ = NB * SH;
  localparam int PW = d * (d + 1) / 2;
  localparam int RW = ROWS * 5 * PW;

  logic          s1_valid_r;
  logic          out_valid_r;
  logic [NQ-1:0] q_r;
  logic [NQ-1:0] q_d_s;
  logic [NB-1:0] out_shares_r;
  logic [NB-1:0] out_d_s;
  logic          s2_adv_s;
  logic          s1_adv_s;
  logic          accept_s;

  // One refreshed share product q[i][j] for output bit k of a row.
  function automatic logic q_term(input logic [NB-1:0] sh, input logic [RW-1:0] rr,
                                  input int row, input int k, input int i, input int j);
    logic x_v;
    logic y_v;
    logic z_v;
    logic m_v;
    int   lo;
    int   hi;
    z_v = sh[(row*5 + k)*SH + i];
    x_v = sh[(row*5 + (k+1)%5)*SH + i] ^ ((i == 0) ? 1'b1 : 1'b0);
    y_v = sh[(row*5 + (k+2)%5)*SH + j];
    if (i == j) begin
      m_v = 1'b0;
    end else begin
      lo  = (i < j) ? i : j;
      hi  = (i < j) ? j : i;
      m_v = rr[row*5*PW + k*PW + lo + hi*(hi-1)/2];
    end
    return (x_v & y_v) ^ ((j == 0) ? z_v : 1'b0) ^ m_v;
  endfunction

  // Fold a group of SH share bits into one bit.
  function automatic logic fold_shares(input logic [NQ-1:0] v, input int base);
    logic acc;
    acc = 1'b0;
    for (int s = 0; s < SH; s++) begin
      acc = acc ^ v[base + s];
    end
    return acc;
  endfunction

  assign s2_adv_s = ~out_valid_r | out_ready;
  assign s1_adv_s = s1_valid_r & s2_adv_s;
  assign in_ready = ~s1_valid_r | s1_adv_s;
  assign accept_s = in_valid & in_ready;

  // Stage 1 expansion: depends on in_shares and r only (glitch barrier input).
  always_comb begin
    q_d_s = '0;
    for (int row = 0; row < ROWS; row++) begin
      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < SH; i++) begin
          for (int j = 0; j < SH; j++) begin
            q_d_s[((row*5 + k)*SH + i)*SH + j] = q_term(in_shares, r, row, k, i, j);
          end
        end
      end
    end
  end

  // Stage 2 compression: out share i is the XOR of its SH products.
  always_comb begin
    out_d_s = '0;
    for (int b = 0; b < NB; b++) begin
      out_d_s[b] = fold_shares(q_r, b*SH);
    end
  end

  // Pipeline occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        s1_valid_r <= 1'b1;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (s1_adv_s) begin
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  // Stage 1 product register, loaded only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (accept_s) begin
      q_r <= q_d_s;
    end else begin
      q_r <= q_r;
    end
  end

  // Output share register, loaded only when stage 1 advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_shares_r <= '0;
    end else if (s1_adv_s) begin
      out_shares_r <= out_d_s;
    end else begin
      out_shares_r <= out_shares_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_shares = out_shares_r;

`ifdef KECCAK_CHI_DBG_EN
  logic [5*ROWS-1:0] plain_r;
  logic [5*ROWS-1:0] plain_d_s;

  // Recombined view of the next output shares.
  always_comb begin
    plain_d_s = '0;
    for (int b = 0; b < 5*ROWS; b++) begin
      for (int s = 0; s < SH; s++) begin
        plain_d_s[b] = plain_d_s[b] ^ out_d_s[b*SH + s];
      end
    end
  end

  // Debug plaintext register, same enable as the share register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plain_r <= '0;
    end else if (s1_adv_s) begin
      plain_r <= plain_d_s;
    end else begin
      plain_r <= plain_r;
    end
  end

  assign out_plain = plain_r;
`endif

endmodule

// File: doc/keccak_chi_pipe.md
Name: keccak_chi_pipe

Overview:
- Pipelined, masked Keccak chi layer at arbitrary security order d, processing ROWS independent 5-bit rows per transaction.
- Stage 1 expands each output bit into (d+1)^2 refreshed share products and registers them as a glitch barrier.
- Stage 2 compresses back to d+1 shares and registers them.
- Sits between the linear layer (theta/rho/pi) and iota in the low-latency masked Keccak datapath, with an elastic valid/ready handshake on both sides.

Parameters:
- d, 1, security order; shares per bit = d+1.
- ROWS, 5, number of 5-bit chi rows per transaction (5 = one plane).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block can accept the input transaction.
- in_shares  input  5*ROWS*(d+1)  input shares; bit index (row*5+pos)*(d+1)+share, pos 0..4 = a..e.
- r  input  ROWS*5*d*(d+1)/2  fresh randomness, sampled with in_shares.
- out_valid  output  1  output transaction valid.
- out_ready  input  1  downstream accepts the output.
- out_shares  output  5*ROWS*(d+1)  output shares, same layout as in_shares.

Behaviour:
- Chi per row: a'=a^(~b&c), b'=b^(~c&d), c'=c^(~d&e), d'=d^(~e&a), e'=e^(~a&b). For output k the terms are (z, x, y): z is the bit being updated, x is the inverted operand, y is the other operand.
- Fresh masks per row and output k: m[i][j]=m[j][i], m[i][i]=0. For i<j, m[i][j] = r[row*5*d*(d+1)/2 + k*d*(d+1)/2 + i + j*(j-1)/2].
- Stage 1 (combinational from inputs, registered on acceptance): q[i][j] = x'_i&y_j ^ (j==0 ? z_i : 0) ^ m[i][j], with x'_0 = ~x_0 and x'_i = x_i for i>0.
- Stage 1 register holds 5*ROWS*(d+1)^2 bits. Its register input must depend only on in_shares and r, never on any other stage.
- Stage 2: out share i = XOR over j of q[i][j], registered in the output register.
- Latency: exactly 2 cycles from acceptance to out_valid with no back-pressure. Throughput: 1 transaction/cycle.
- Handshake:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = ~s1_valid | s1_adv.
  - Acceptance = in_valid & in_ready.
- Stage 1 data loads only on acceptance. Output data loads only on s1_adv. Otherwise both hold their values; no clock-enable-free toggling, to keep the leakage model stable.
- s1_valid next = acceptance ? 1 : (s1_adv ? 0 : s1_valid).
- out_valid next = s1_adv ? 1 : (out_ready ? 0 : out_valid).
- Simultaneous accept and advance: both occur in the same cycle, with no bubble.
- Full stall (both valid, out_ready=0): in_ready=0, and all registers hold.
- in_valid may drop without acceptance; no data is captured in that case.
- Reset (async, any time including mid-transaction): s1_valid=0, out_valid=0, all data registers=0. in_ready is therefore 1 after reset. In-flight transactions are discarded.
- r is consumed only on acceptance. r values supplied without acceptance are ignored.

Optional Feature:
- Macro KECCAK_CHI_DBG_EN.
- Defined: adds output port out_plain (5*ROWS), the XOR of the out_shares shares per bit. It is registered alongside out_shares and follows the same valid/hold rules. Simulation and debug only.
- Undefined: the port and its logic are absent. Share datapath behaviour is identical in both cases.

Test Plan:
- d=1, ROWS=1, r=0, unmasked a..e=1,0,1,0,0 (shares {x,0}), accept at cycle 0 -> out_valid at cycle 2; recombined out = a..e 0,0,1,1,0 (0x0C).
- Same input with random r and random input share split, over 1000 transactions -> recombined output always 0x0C; all-zero input -> 0x00; all-ones input -> 0x1F.
- Back-to-back stream of 8 transactions, out_ready=1 -> in_ready stays 1, outputs arrive in order, one per cycle, each 2 cycles after its acceptance.
- out_ready=0 for 4 cycles during the stream -> in_ready falls after 2 accepted transactions; out_shares is stable while stalled; no loss or duplication after out_ready returns to 1.
- Assert rst for 1 cycle mid-stall -> out_valid=0, out_shares=0, in_ready=1 immediately; no stale output appears afterwards.
- d=2, ROWS=5, random planes vs. a golden chi model with randomised out_ready -> all recombined outputs match; r sampled only on acceptance cycles.
